// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring-divider controller.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SUB  = 3'd2,
    TEST = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] SEL_ADDER = 2'b01;
  localparam logic [1:0] SEL_LOAD  = 2'b10;
  localparam logic [1:0] SEL_HOLD  = 2'b11;

endpackage

// File: rtl/divider_if.sv
// Controller <-> datapath/system signal bundle; master is the controller side.
interface divider_if;
  logic       start;
  logic       sign;
  logic       load;
  logic       add;
  logic       shift;
  logic       inbit;
  logic [1:0] sel;
  logic       busy;
  logic       done;

  modport master (input  start, sign,
                  output load, add, shift, inbit, sel, busy, done);
  modport slave  (output start, sign,
                  input  load, add, shift, inbit, sel, busy, done);
endinterface

// File: rtl/divider_controller.sv
// Control FSM for the 8/7-bit restoring divider: one load-and-shift,
// then N_ITER subtract/test iterations, then a one-cycle done pulse.
module divider_controller
  import divider_pkg::*;
#(
  parameter int N_ITER = 8,
  parameter int CNT_W  = 3
) (
  input  logic     clk,
  input  logic     reset,
  divider_if.master bus
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bus.load  = 1'b0;
    bus.add   = 1'b0;
    bus.shift = 1'b0;
    bus.inbit = 1'b0;
    bus.sel   = SEL_HOLD;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;

    case (state)
      IDLE: if (bus.start) state_nxt = LOAD;

      LOAD: begin
        bus.load  = 1'b1;
        bus.sel   = SEL_LOAD;
        bus.shift = 1'b1;
        bus.busy  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = SUB;
      end

      SUB: begin
        bus.sel   = SEL_ADDER;
        bus.busy  = 1'b1;
        state_nxt = TEST;
      end

      // Negative trial: add divisor back before shifting in a 0.
      // Non-negative: keep the difference and shift in a 1.
      TEST: begin
        bus.busy  = 1'b1;
        bus.shift = 1'b1;
        if (bus.sign) begin
          bus.sel   = SEL_ADDER;
          bus.add   = 1'b1;
          bus.inbit = 1'b0;
        end else begin
          bus.sel   = SEL_HOLD;
          bus.add   = 1'b0;
          bus.inbit = 1'b1;
        end
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(N_ITER - 1)) state_nxt = DONE;
        else                           state_nxt = SUB;
      end

      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_divider_controller.sv
// Scoreboard bench: controller driving a behavioural 8/7-bit restoring datapath.
module tb_divider_controller;
  import divider_pkg::*;

  localparam int N_ITER = 8;
  localparam int LAT    = 2 * N_ITER + 1;
  localparam int BUSY_N = 2 * N_ITER + 1;

  localparam logic [7:0] O_IDLE  = 8'b0000_1100;
  localparam logic [7:0] O_TNEG  = 8'b0110_0110;
  localparam logic [7:0] O_TPOS  = 8'b0011_1110;

  typedef struct {
    logic [7:0] q;
    logic [6:0] r;
    bit         chk_data;
    int         start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  divider_if bus();

  divider_controller #(.N_ITER(N_ITER), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural datapath plant
  logic [7:0]  dvd_in = '0;
  logic [6:0]  dvs_in = '0;
  logic [6:0]  divreg = '0;
  logic [15:0] rem = '0;
  logic [15:0] mux;
  logic [7:0]  adder;
  logic        force_en = 1'b0;
  logic        force_val = 1'b0;

  assign adder    = bus.add ? rem[15:8] + {1'b0, divreg} : rem[15:8] - {1'b0, divreg};
  assign bus.sign = force_en ? force_val : rem[15];

  always_comb begin
    case (bus.sel)
      SEL_LOAD:  mux = {8'b0, dvd_in};
      SEL_ADDER: mux = {adder, rem[7:0]};
      default:   mux = rem;
    endcase
  end

  always @(posedge clk) begin
    if (bus.load) divreg <= dvs_in;
    rem <= bus.shift ? {mux[14:0], bus.inbit} : mux;
  end

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   done_cnt = 0;
  int   bcnt = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] outs();
    return {bus.load, bus.add, bus.shift, bus.inbit, bus.sel, bus.busy, bus.done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation on every done pulse
  always @(negedge clk) begin
    if (reset) bcnt = 0;
    else begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_latency", cyc - e.start_cyc, LAT);
          check("busy_cycles", bcnt, BUSY_N);
          if (e.chk_data) begin
            check("quotient", {24'b0, rem[7:0]}, {24'b0, e.q});
            check("remainder", {25'b0, rem[15:9]}, {25'b0, e.r});
          end
        end
        bcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] dvd, input logic [6:0] dvs,
                       input logic [7:0] q, input logic [6:0] r, input bit chk);
    exp_t e;
    dvd_in    = dvd;
    dvs_in    = dvs;
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    e.q         = q;
    e.r         = r;
    e.chk_data  = chk;
    e.start_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 40) begin
      tick();
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask

  typedef struct { logic [7:0] dvd; logic [6:0] dvs; logic [7:0] q; logic [6:0] r; } vec_t;
  vec_t vecs[4];

  initial begin
    vecs[0] = '{8'd100, 7'd7,   8'd14,  7'd2};
    vecs[1] = '{8'd255, 7'd1,   8'd255, 7'd0};
    vecs[2] = '{8'd5,   7'd127, 8'd0,   7'd5};
    vecs[3] = '{8'd0,   7'd0,   8'hFF,  7'd0};

    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", {24'b0, outs()}, {24'b0, O_IDLE});
      tick();
    end

    foreach (vecs[i]) begin
      issue(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, 1'b1);
      wait_done();
      tick();
    end

    // Forced sign: check TEST decode in every iteration
    force_en = 1'b1;
    for (int s = 1; s >= 0; s--) begin
      force_val = s[0];
      issue(8'd0, 7'd1, 8'd0, 7'd0, 1'b0);
      for (int k = 1; k <= 2 * N_ITER + 1; k++) begin
        if (k >= 3 && k[0])
          check(s ? "test_sign1" : "test_sign0", {24'b0, outs()}, {24'b0, s ? O_TNEG : O_TPOS});
        tick();
      end
      wait_done();
      tick();
    end
    force_en = 1'b0;

    // start pulses at cycles 5 and 12 of a running division are ignored
    issue(8'd100, 7'd7, 8'd14, 7'd2, 1'b1);
    repeat (4) tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (6) tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_done();
    repeat (3) tick();
    check("no_queued_start", {31'b0, bus.busy}, 0);
    issue(8'd255, 7'd1, 8'd255, 7'd0, 1'b1);
    wait_done();
    tick();

    // Reset in the 3rd SUB cycle aborts without a done pulse
    issue(8'd100, 7'd7, 8'd0, 7'd0, 1'b1);
    void'(sb.pop_back());
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_idle", {24'b0, outs()}, {24'b0, O_IDLE});
    repeat (25) tick();
    issue(8'd200, 7'd13, 8'd15, 7'd5, 1'b1);
    wait_done();
    repeat (2) tick();

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
